// File: rtl/countdown_pkg.sv
// Shared types and constants for the pre-round countdown overlay.
package countdown_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHOW3,
        SHOW2,
        SHOW1,
        SHOWF
    } cd_state_t;

    localparam logic [1:0] CD_SEL_THREE = 2'd0;
    localparam logic [1:0] CD_SEL_TWO   = 2'd1;
    localparam logic [1:0] CD_SEL_ONE   = 2'd2;
    localparam logic [1:0] CD_SEL_FIGHT = 2'd3;

    // Chroma-green palette entry of each countdown palette, treated as transparent.
    localparam logic [1:0] KEY_INDEX [0:3] = '{2'd0, 2'd1, 2'd0, 2'd1};

endpackage

// File: rtl/countdown_overlay_ctrl_if.sv
// Pixel, sprite-ROM and sequence-control signals between the overlay controller and its peers.
interface countdown_overlay_ctrl_if #(
    parameter int unsigned ADDR_W = 14
);
    logic              start;
    logic              frame_tick;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic [ADDR_W-1:0] rom_addr;
    logic [1:0]        rom_data;
    logic [1:0]        pal_sel;
    logic [1:0]        pix_index;
    logic              pix_valid;
    logic              busy;
    logic              done;

    modport master (
        output start, frame_tick, DrawX, DrawY, rom_data,
        input  rom_addr, pal_sel, pix_index, pix_valid, busy, done
    );

    modport slave (
        input  start, frame_tick, DrawX, DrawY, rom_data,
        output rom_addr, pal_sel, pix_index, pix_valid, busy, done
    );
endinterface

// File: rtl/countdown_seq_fsm.sv
// "3, 2, 1, FIGHT" step sequencer: advances one step every FRAMES_PER_STEP frame ticks.
module countdown_seq_fsm
    import countdown_pkg::*;
#(
    parameter int unsigned FRAMES_PER_STEP = 60
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       frame_tick_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [1:0] sel_o
);
    localparam int unsigned CntW =
        ($clog2(FRAMES_PER_STEP) > 6) ? $clog2(FRAMES_PER_STEP) : 6;
    localparam logic [CntW-1:0] CntLast = CntW'(FRAMES_PER_STEP - 1);

    cd_state_t       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A tick coinciding with start is not counted.
                if (start_i) begin
                    state_d = SHOW3;
                    cnt_d   = '0;
                end
            end
            SHOW3, SHOW2, SHOW1, SHOWF: begin
                if (frame_tick_i) begin
                    if (cnt_q == CntLast) begin
                        cnt_d = '0;
                        unique case (state_q)
                            SHOW3:   state_d = SHOW2;
                            SHOW2:   state_d = SHOW1;
                            SHOW1:   state_d = SHOWF;
                            default: begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        endcase
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        sel_o = CD_SEL_THREE;
        unique case (state_q)
            SHOW2:   sel_o = CD_SEL_TWO;
            SHOW1:   sel_o = CD_SEL_ONE;
            SHOWF:   sel_o = CD_SEL_FIGHT;
            default: sel_o = CD_SEL_THREE;
        endcase
    end

    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: rtl/countdown_overlay_ctrl.sv
// Countdown overlay: sequencer plus a 3-stage pixel pipeline through the sprite ROM.
module countdown_overlay_ctrl
    import countdown_pkg::*;
#(
    parameter int unsigned BOX_X0          = 256,
    parameter int unsigned BOX_Y0          = 176,
    parameter int unsigned BOX_W           = 128,
    parameter int unsigned BOX_H           = 128,
    parameter int unsigned FRAMES_PER_STEP = 60,
    parameter int unsigned ADDR_W          = 14
) (
    input  logic                     Clk,
    input  logic                     Reset,
    countdown_overlay_ctrl_if.slave  bus
);
    localparam int unsigned XW = $clog2(BOX_W);
    localparam int unsigned YW = ADDR_W - XW;

    localparam logic [9:0] XLo = 10'(BOX_X0);
    localparam logic [9:0] XHi = 10'(BOX_X0 + BOX_W - 1);
    localparam logic [9:0] YLo = 10'(BOX_Y0);
    localparam logic [9:0] YHi = 10'(BOX_Y0 + BOX_H - 1);

    logic       seq_busy;
    logic       seq_done;
    logic [1:0] seq_sel;

    countdown_seq_fsm #(
        .FRAMES_PER_STEP(FRAMES_PER_STEP)
    ) u_seq (
        .clk_i       (Clk),
        .rst_i       (Reset),
        .start_i     (bus.start),
        .frame_tick_i(bus.frame_tick),
        .busy_o      (seq_busy),
        .done_o      (seq_done),
        .sel_o       (seq_sel)
    );

    logic              in_box;
    logic [XW-1:0]     dx;
    logic [YW-1:0]     dy;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              in_box_s1_q, in_box_s2_q;
    logic              busy_s1_q, busy_s2_q;
    logic [1:0]        sel_s1_q, sel_s2_q;
    logic [1:0]        pal_sel_q;
    logic [1:0]        pix_index_q;
    logic              pix_valid_q, pix_valid_d;

    // Offsets fit in the low bits because they are only used when in the box.
    always_comb begin
        in_box = (bus.DrawX >= XLo) && (bus.DrawX <= XHi) &&
                 (bus.DrawY >= YLo) && (bus.DrawY <= YHi);
        dx     = bus.DrawX[XW-1:0] - XLo[XW-1:0];
        dy     = bus.DrawY[YW-1:0] - YLo[YW-1:0];
        rom_addr_d  = in_box ? {dy, dx} : rom_addr_q;
        pix_valid_d = busy_s2_q & in_box_s2_q & (bus.rom_data != KEY_INDEX[sel_s2_q]);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr_q  <= '0;
            in_box_s1_q <= 1'b0;
            in_box_s2_q <= 1'b0;
            busy_s1_q   <= 1'b0;
            busy_s2_q   <= 1'b0;
            sel_s1_q    <= '0;
            sel_s2_q    <= '0;
            pal_sel_q   <= '0;
            pix_index_q <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            rom_addr_q  <= rom_addr_d;
            in_box_s1_q <= in_box;
            busy_s1_q   <= seq_busy;
            sel_s1_q    <= seq_sel;
            in_box_s2_q <= in_box_s1_q;
            busy_s2_q   <= busy_s1_q;
            sel_s2_q    <= sel_s1_q;
            pal_sel_q   <= sel_s2_q;
            pix_index_q <= bus.rom_data;
            pix_valid_q <= pix_valid_d;
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.pal_sel   = pal_sel_q;
    assign bus.pix_index = pix_index_q;
    assign bus.pix_valid = pix_valid_q;
    assign bus.busy      = seq_busy;
    assign bus.done      = seq_done;

endmodule

// File: tb/tb_countdown_overlay_ctrl.sv
// Randomized scoreboard bench for countdown_overlay_ctrl against a step-count reference model.
module tb_countdown_overlay_ctrl;

    localparam int F  = 2;
    localparam int X0 = 256;
    localparam int Y0 = 176;
    localparam int W  = 128;
    localparam int H  = 128;

    typedef struct {
        bit inb;
        bit busy;
        int sel;
        int addr;
    } rec_t;

    typedef struct {
        bit busy;
        bit done;
        int sel;
        bit valid;
        int idx;
        int addr;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset = 1'b1;

    countdown_overlay_ctrl_if #(.ADDR_W(14)) bus ();

    countdown_overlay_ctrl #(
        .BOX_X0         (X0),
        .BOX_Y0         (Y0),
        .BOX_W          (W),
        .BOX_H          (H),
        .FRAMES_PER_STEP(F),
        .ADDR_W         (14)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    // Synchronous sprite ROM with random contents.
    logic [1:0] mem [0:16383];
    always @(posedge Clk) bus.rom_data <= mem[bus.rom_addr];

    int   key_tab [4] = '{0, 1, 0, 1};
    rec_t pq [$];
    exp_t exp_q [$];
    bit   active;
    int   tcnt;
    int   held;
    int   total = 0;
    int   bad = 0;

    function automatic rec_t zero_rec();
        rec_t r;
        r.inb = 0; r.busy = 0; r.sel = 0; r.addr = 0;
        return r;
    endfunction

    // One clock: drive inputs, advance the model across the coming edge, queue expectation.
    task automatic cyc(input bit rst, input bit st, input bit tk, input int x, input int y);
        rec_t r;
        rec_t old;
        exp_t e;
        bit   inb;
        @(negedge Clk);
        Reset          = rst;
        bus.start      = st;
        bus.frame_tick = tk;
        bus.DrawX      = x[9:0];
        bus.DrawY      = y[9:0];
        e.busy = 0; e.done = 0; e.sel = 0; e.valid = 0; e.idx = 0; e.addr = 0;
        if (rst) begin
            active = 0;
            tcnt   = 0;
            held   = 0;
            pq.delete();
            pq.push_back(zero_rec());
            pq.push_back(zero_rec());
        end else begin
            inb = (x >= X0) && (x < X0 + W) && (y >= Y0) && (y < Y0 + H);
            if (inb) held = (y - Y0) * W + (x - X0);
            r.inb  = inb;
            r.busy = active;
            r.sel  = active ? tcnt / F : 0;
            r.addr = held;
            old = pq.pop_front();
            pq.push_back(r);
            if (!active) begin
                if (st) begin
                    active = 1;
                    tcnt   = 0;
                end
            end else if (tk) begin
                tcnt++;
                if (tcnt == 4 * F) begin
                    active = 0;
                    tcnt   = 0;
                    e.done = 1;
                end
            end
            e.busy  = active;
            e.sel   = old.sel;
            e.idx   = mem[old.addr];
            e.valid = old.busy && old.inb && (int'(mem[old.addr]) != key_tab[old.sel]);
            e.addr  = held;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: one expectation per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (bus.busy !== e.busy || bus.done !== e.done) begin
                    bad++;
                    $display("FAIL seq @%0t: busy/done got %b/%b want %b/%b",
                             $time, bus.busy, bus.done, e.busy, e.done);
                end
                total++;
                if (bus.pix_valid !== e.valid || bus.pal_sel !== 2'(e.sel)) begin
                    bad++;
                    $display("FAIL pix @%0t: valid/pal_sel got %b/%0d want %b/%0d",
                             $time, bus.pix_valid, bus.pal_sel, e.valid, e.sel);
                end
                if (e.valid) begin
                    total++;
                    if (bus.pix_index !== 2'(e.idx)) begin
                        bad++;
                        $display("FAIL index @%0t: got %0d want %0d",
                                 $time, bus.pix_index, e.idx);
                    end
                end
                total++;
                if (bus.rom_addr !== 14'(e.addr)) begin
                    bad++;
                    $display("FAIL rom_addr @%0t: got %0d want %0d",
                             $time, bus.rom_addr, e.addr);
                end
            end
        end
    end

    int bx [8] = '{256, 383, 255, 384, 300, 300, 256, 383};
    int by [8] = '{176, 303, 176, 200, 175, 304, 303, 176};

    initial begin
        int x;
        int y;
        int k;
        for (int i = 0; i < 16384; i++) mem[i] = 2'($urandom);
        bus.start      = 1'b0;
        bus.frame_tick = 1'b0;
        bus.DrawX      = '0;
        bus.DrawY      = '0;
        repeat (3) cyc(1, 0, 0, 0, 0);

        // Idle sweep of a full in-box line, with stray ticks.
        for (int i = 0; i < W; i++) cyc(0, 0, (i % 37) == 0, X0 + i, 200);

        // Start coinciding with a tick, then a full sequence over boundary pixels.
        cyc(0, 1, 1, 300, 200);
        for (int s = 0; s < 9; s++) begin
            for (int c = 0; c < 16; c++) begin
                k = $urandom_range(0, 9);
                if (k < 8) begin
                    x = bx[k];
                    y = by[k];
                end else begin
                    x = $urandom_range(X0, X0 + W - 1);
                    y = $urandom_range(Y0, Y0 + H - 1);
                end
                cyc(0, (c == 3), (c == 15), x, y);
            end
        end

        // Reset in the middle of SHOW1 with in-box pixels.
        cyc(0, 1, 0, 300, 250);
        for (int t = 0; t < 2 * F; t++) begin
            repeat (4) cyc(0, 0, 0, 320, 240);
            cyc(0, 0, 1, 320, 240);
        end
        repeat (5) cyc(0, 0, 0, $urandom_range(X0, X0 + W - 1), $urandom_range(Y0, Y0 + H - 1));
        cyc(1, 0, 0, 330, 250);
        repeat (6) cyc(0, 0, 0, $urandom_range(X0, X0 + W - 1), $urandom_range(Y0, Y0 + H - 1));

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            x = $urandom_range(240, 400);
            y = $urandom_range(160, 320);
            if ($urandom_range(0, 9) == 0) begin
                k = $urandom_range(0, 7);
                x = bx[k];
                y = by[k];
            end
            cyc(($urandom_range(0, 599) == 0), ($urandom_range(0, 49) == 0),
                ($urandom_range(0, 11) == 0), x, y);
        end

        repeat (3) @(posedge Clk);
        #2;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/countdown_overlay_ctrl.md
Name: countdown_overlay_ctrl

Overview:
- Upstream stage of the countdown palette modules.
- Runs the pre-round "3, 2, 1, FIGHT" overlay sequence, one step per fixed number of video frames.
- For each pixel, generates the sprite-ROM address from DrawX/DrawY, pipelines the 2-bit ROM data, and presents it as a palette index. It also outputs the palette select (which countdown palette) and a transparency-keyed pixel-valid flag to the colour mapper.

Parameters:
- BOX_X0, 256, left edge of overlay box (pixels)
- BOX_Y0, 176, top edge of overlay box (pixels)
- BOX_W, 128, box width; must be a power of two
- BOX_H, 128, box height
- FRAMES_PER_STEP, 60, frame_tick count per digit/FIGHT step
- ADDR_W, 14, ROM address width; log2(BOX_W*BOX_H)

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins the sequence
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- DrawX  in  10  current pixel x
- DrawY  in  10  current pixel y
- rom_addr  out  ADDR_W  address to the countdown sprite ROM (synchronous, 1-cycle read)
- rom_data  in  2  ROM palette index, valid 1 cycle after rom_addr
- pal_sel  out  2  palette select: 0=three, 1=two, 2=one, 3=fight (pixel-aligned)
- pix_index  out  2  palette index to the countdown palette
- pix_valid  out  1  1 = draw overlay pixel, 0 = show underlying layer
- busy  out  1  sequence running
- done  out  1  one-cycle pulse when the FIGHT step ends

Behaviour:
- Reset: state IDLE, frame counter 0, all pipeline registers 0. rom_addr, pal_sel, pix_index, pix_valid, busy and done all 0.
- FSM states: IDLE, SHOW3, SHOW2, SHOW1, SHOWF.
  - IDLE: start -> SHOW3, frame counter cleared.
  - Show states: on frame_tick, if counter == FRAMES_PER_STEP-1, advance (SHOW3->SHOW2->SHOW1->SHOWF) and clear the counter; otherwise increment the counter.
  - SHOWF terminal tick: go to IDLE and assert done for exactly that one cycle.
  - Counter is 6 bits min, sized by $clog2(FRAMES_PER_STEP).
- Transitions happen only on frame_tick, so the state is constant across a visible frame.
- start while busy is ignored.
- start and frame_tick in the same cycle in IDLE: start wins; that tick is not counted.
- busy = (state != IDLE), registered with the state.
- Live palette select for SHOW3/SHOW2/SHOW1/SHOWF = 0/1/2/3.
- Pixel pipeline, fixed 3-cycle latency from DrawX/DrawY to pix_index/pix_valid:
  - Cycle t: in_box = DrawX in [BOX_X0, BOX_X0+BOX_W-1] and DrawY in [BOX_Y0, BOX_Y0+BOX_H-1].
  - Cycle t+1: rom_addr registered as {DrawY-BOX_Y0, DrawX-BOX_X0} (row-major, low log2(BOX_W) bits are x). Register in_box, busy and the live palette select alongside it.
  - Cycle t+2: rom_data arrives; delay the sideband by one more stage.
  - Cycle t+3: pix_index <= rom_data; pal_sel <= the palette select aligned with that pixel. pix_valid <= busy_d & in_box_d & (rom_data != KEY_INDEX[pal_sel_d]).
- Out-of-box pixels: rom_addr holds its previous value, pix_valid 0.
- Subtraction uses 10-bit unsigned arithmetic, evaluated only when in_box, so there is no wrap.
- Transparency key table (chroma-green entry per palette): KEY_INDEX = {0, 1, 0, 1} for pal_sel 0..3.
- Reset mid-sequence: everything returns to the reset values on the next edge. No done pulse is issued and the pipeline is flushed, so pix_valid is 0 for the next 3 cycles regardless of DrawX/DrawY.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package countdown_pkg:
  - enum cd_state_t {IDLE, SHOW3, SHOW2, SHOW1, SHOWF}
  - localparam KEY_INDEX[0:3]
  - pal_sel encodings CD_SEL_THREE/TWO/ONE/FIGHT
- One sub-module, countdown_seq_fsm: state, frame counter, busy, done, live palette select.
- The pixel pipeline stays in the top module.

Test Plan:
- Reset, FRAMES_PER_STEP=2, start pulse, 8 frame_ticks:
  - busy=1 the cycle after start.
  - Live select steps 0,0,1,1,2,2,3,3 per tick.
  - done pulses once on the 8th tick; busy=0 after.
- SHOW3, DrawX=256/DrawY=176 -> rom_addr=0 at t+1. DrawX=383/DrawY=303 -> rom_addr=16383. DrawX=255/DrawY=176 -> pix_valid=0 at t+3.
- Keying:
  - pal_sel=1 (SHOW2), in box, rom_data=1 -> pix_valid=0.
  - rom_data=2 -> pix_valid=1, pix_index=2, 3 cycles after DrawX/DrawY.
  - pal_sel=0, rom_data=0 -> pix_valid=0.
- Second start 3 cycles into SHOW2 -> ignored, sequence unchanged. Start coincident with frame_tick in IDLE -> SHOW3 with counter 0.
- Reset asserted in SHOW1 with pixels in box -> busy=0 and pal_sel=0 next cycle, pix_valid=0 for ≥3 cycles, no done pulse.
- Idle, in-box sweep of a full line -> pix_valid stays 0 throughout.
